ddram_mux: RTL and testbench
============================

// Module: ddram_mux
// PURPOSE
// - N-channel DDR3 Avalon-MM front end for core-side memories (ROM fetch, RAM, save-state, misc) behind one DDRAM port.
// - Generalises the fixed 4-channel mux: parametrised channel count, round-robin arbitration, per-channel byte-lane writes.
// - Adds optional single-line read cache per channel; any write invalidates every cached line at the same address.
// - Sits between core memory controllers and the sys DDRAM_* interface; all logic runs on DDRAM_CLK.
// PARAMETERS
// - NUM_CH      4         channels, 1..8; index 0 = channel 0
// - BASE_ADDR   4'b0011   DDRAM_ADDR[28:25]; places the core window at 0x30000000
// - CACHE_MASK  8'h03     bit i set = channel i keeps a 64-bit read line cache
// - MAX_BURST   2         max DDRAM_BURSTCNT issued: 1, or 2 for line+prefetch
// PORTS
// - DDRAM_CLK         in   1          sole clock
// - DDRAM_RESET_N     in   1          async assert, active-low; deassertion synchronised internally
// - DDRAM_BUSY        in   1          Avalon waitrequest
// - DDRAM_BURSTCNT    out  8          burst length
// - DDRAM_ADDR        out  29         {BASE_ADDR, addr[27:3]}
// - DDRAM_DOUT        in   64         read data
// - DDRAM_DOUT_READY  in   1          read data valid
// - DDRAM_RD          out  1          read command
// - DDRAM_DIN         out  64         write data
// - DDRAM_BE          out  8          byte enables; 8'hFF on reads
// - DDRAM_WE          out  1          write command
// - ch_addr           in   NUM_CH*25  per-channel 64-bit word address [27:3]
// - ch_din            in   NUM_CH*64  write data, byte-lane aligned
// - ch_be             in   NUM_CH*8   write byte enables; 0 = no-op write
// - ch_req            in   NUM_CH     1-cycle request strobe
// - ch_rnw            in   NUM_CH     1 = read, 0 = write
// - ch_dout           out  NUM_CH*64  read line, held until the channel's next read completes
// - ch_ready          out  NUM_CH     1-cycle completion pulse
// BEHAVIOUR
// - Reset: DDRAM_RD/WE = 0, BURSTCNT = 1, BE = 0, ch_ready = 0, ch_dout = 0, pending = 0, cache valid = 0, rr pointer = 0.
// - Handshake: ch_req latches into pending[i] together with addr/din/be/rnw. A req while pending[i] is set is dropped; the bench must wait for ch_ready.
// - Arbitration: in IDLE, grant the lowest pending index at or after rr_ptr (wrapping). After each grant, rr_ptr = grant+1 mod NUM_CH.
// - Commands hold while DDRAM_BUSY = 1 and drop the cycle after acceptance.
// - FSM states: IDLE, CMD, RD1, RD2.
// - Write: IDLE -> CMD. ch_ready pulses the cycle after the write is accepted, then IDLE.
// - Write side effect: every channel's cache line with a matching addr is invalidated, including the writer's own line.
// - Read hit (cached channel, valid, same addr): ch_ready 1 cycle after grant, no DDR access, stays IDLE.
// - Read miss: CMD -> RD1. On the first DOUT_READY, load ch_dout, pulse ch_ready, set valid.
//   Then go to IDLE if burst = 1, else RD2.
// - RD2: the second beat is written to the channel's prefetch register, then IDLE. No grant is issued while in RD2.
// - Simultaneous req from all channels: served in round-robin order; each channel completes exactly once.
// - Reset mid-burst: all pending requests and cache lines are discarded. Late DOUT_READY beats after reset are ignored until the next RD.
// CONFIGURATION
// - DDRAM_PREFETCH_EN defined: cache misses use burst 2; the 2nd beat fills the prefetch register.
//   A read of addr+1 swaps prefetch into the line, pulses ch_ready 1 cycle after grant, and issues a burst-1 refill of addr+2 into prefetch.
//   Any write invalidates a matching prefetch register.
// - Not defined: all reads use burst 1, no prefetch registers; RD2 is unreachable. MAX_BURST is ignored.
// TESTING
// - Reset release, NUM_CH=4 -> all outputs at reset values; no DDRAM_RD/WE for 100 cycles.
// - Ch0 read 0x100 (miss) then 0x100 again -> one DDRAM_RD with ADDR = 0x06000020; second ch_ready 1 cycle after grant with identical ch_dout.
// - Ch1 write be=8'h0F din=0x11223344 to addr 0x40 while ch0 caches 0x40 -> DDRAM_BE = 0x0F; ch0's next read of 0x40 re-issues DDRAM_RD.
// - All 4 req in the same cycle, rr_ptr = 2 -> grant order 2, 3, 0, 1; four ch_ready pulses.
// - DDRAM_BUSY held 10 cycles during a write -> WE/ADDR/DIN stable for all 10 cycles; ch_ready 1 cycle after BUSY falls.
// - DDRAM_PREFETCH_EN: ch0 reads 0x200 then 0x201 -> first access uses BURSTCNT = 2; second read ready in 1 cycle; next DDR read is burst 1 at 0x202.

Source files
------------

// File: rtl/ddram_mux.sv
// ddram_mux: N-channel round-robin Avalon-MM front end onto a single DDRAM port, with an optional per-channel read line cache.
// Optional feature macro DDRAM_PREFETCH_EN: cache misses fetch a 2-beat burst and keep the second beat as a prefetch line.
module ddram_mux #(
    parameter int         NUM_CH     = 4,
    parameter logic [3:0] BASE_ADDR  = 4'b0011,
    parameter logic [7:0] CACHE_MASK = 8'h03,
    parameter int         MAX_BURST  = 2
) (
    input  logic                 DDRAM_CLK,
    input  logic                 DDRAM_RESET_N,
    input  logic                 DDRAM_BUSY,
    output logic [7:0]           DDRAM_BURSTCNT,
    output logic [28:0]          DDRAM_ADDR,
    input  logic [63:0]          DDRAM_DOUT,
    input  logic                 DDRAM_DOUT_READY,
    output logic                 DDRAM_RD,
    output logic [63:0]          DDRAM_DIN,
    output logic [7:0]           DDRAM_BE,
    output logic                 DDRAM_WE,
    input  logic [NUM_CH*25-1:0] ch_addr,
    input  logic [NUM_CH*64-1:0] ch_din,
    input  logic [NUM_CH*8-1:0]  ch_be,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_rnw,
    output logic [NUM_CH*64-1:0] ch_dout,
    output logic [NUM_CH-1:0]    ch_ready
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [NUM_CH-1:0] CACHED = CACHE_MASK[NUM_CH-1:0];
`ifdef DDRAM_PREFETCH_EN
    localparam logic [7:0] MISS_BURST = (MAX_BURST >= 2) ? 8'd2 : 8'd1;
`else
    // Misses are always single-beat when no prefetch register exists to take a second beat.
    localparam logic [7:0] MISS_BURST = 8'(MAX_BURST > 0);
`endif

    typedef enum logic [1:0] {IDLE, CMD, RD1, RD2} state_t;

    logic [1:0]  rst_sync_q;
    logic        rst_n;

    state_t      state_q, state_d;
    logic [CW-1:0] rr_q, rr_d, gnt_q, gnt_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [24:0] req_addr_q [NUM_CH];
    logic [24:0] req_addr_d [NUM_CH];
    logic [63:0] req_din_q  [NUM_CH];
    logic [63:0] req_din_d  [NUM_CH];
    logic [7:0]  req_be_q   [NUM_CH];
    logic [7:0]  req_be_d   [NUM_CH];
    logic [NUM_CH-1:0] req_rnw_q, req_rnw_d;

    logic [NUM_CH-1:0] line_valid_q, line_valid_d;
    logic [24:0] line_addr_q [NUM_CH];
    logic [24:0] line_addr_d [NUM_CH];
    logic [63:0] dout_q [NUM_CH];
    logic [63:0] dout_d [NUM_CH];
    logic [NUM_CH-1:0] ready_q, ready_d;

    logic        rd_q, rd_d, we_q, we_d;
    logic [24:0] addr_q, addr_d;
    logic [63:0] din_q, din_d;
    logic [7:0]  be_q, be_d, burst_q, burst_d;

    logic        gnt_found, line_hit;
    logic [CW-1:0] gnt_idx;
    logic [CW:0] rr_idx;
    logic [24:0] g_addr;

`ifdef DDRAM_PREFETCH_EN
    logic [NUM_CH-1:0] pf_valid_q, pf_valid_d;
    logic [24:0] pf_addr_q [NUM_CH];
    logic [24:0] pf_addr_d [NUM_CH];
    logic [63:0] pf_data_q [NUM_CH];
    logic [63:0] pf_data_d [NUM_CH];
    logic        refill_q, refill_d, pf_hit;
`endif

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge DDRAM_CLK or negedge DDRAM_RESET_N) begin
        if (!DDRAM_RESET_N) rst_sync_q <= 2'b00;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        pend_d       = pend_q;
        req_addr_d   = req_addr_q;
        req_din_d    = req_din_q;
        req_be_d     = req_be_q;
        req_rnw_d    = req_rnw_q;
        line_valid_d = line_valid_q;
        line_addr_d  = line_addr_q;
        dout_d       = dout_q;
        ready_d      = '0;
        rd_d         = rd_q;
        we_d         = we_q;
        addr_d       = addr_q;
        din_d        = din_q;
        be_d         = be_q;
        burst_d      = burst_q;
        gnt_found    = 1'b0;
        gnt_idx      = '0;
        rr_idx       = '0;
`ifdef DDRAM_PREFETCH_EN
        pf_valid_d   = pf_valid_q;
        pf_addr_d    = pf_addr_q;
        pf_data_d    = pf_data_q;
        refill_d     = refill_q;
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_req[i] && !pend_q[i]) begin
                pend_d[i]     = 1'b1;
                req_addr_d[i] = ch_addr[i*25 +: 25];
                req_din_d[i]  = ch_din[i*64 +: 64];
                req_be_d[i]   = ch_be[i*8 +: 8];
                req_rnw_d[i]  = ch_rnw[i];
            end
        end

        for (int k = 0; k < NUM_CH; k++) begin
            rr_idx = {1'b0, rr_q} + (CW+1)'(k);
            if (rr_idx >= (CW+1)'(NUM_CH)) rr_idx = rr_idx - (CW+1)'(NUM_CH);
            if (!gnt_found && pend_q[rr_idx[CW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx[CW-1:0];
            end
        end

        g_addr   = req_addr_q[gnt_idx];
        line_hit = CACHED[gnt_idx] && line_valid_q[gnt_idx] && (line_addr_q[gnt_idx] == g_addr);
`ifdef DDRAM_PREFETCH_EN
        pf_hit   = CACHED[gnt_idx] && pf_valid_q[gnt_idx] && (pf_addr_q[gnt_idx] == g_addr);
`endif

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    pend_d[gnt_idx] = 1'b0;
                    rr_d   = (gnt_idx == CW'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
                    gnt_d  = gnt_idx;
                    addr_d = g_addr;
                    if (!req_rnw_q[gnt_idx]) begin
                        // An all-zero byte mask completes without touching DDR or the caches.
                        if (req_be_q[gnt_idx] == 8'h00) begin
                            ready_d[gnt_idx] = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            din_d   = req_din_q[gnt_idx];
                            be_d    = req_be_q[gnt_idx];
                            burst_d = 8'd1;
                            state_d = CMD;
                            for (int j = 0; j < NUM_CH; j++) begin
                                if (line_addr_q[j] == g_addr) line_valid_d[j] = 1'b0;
`ifdef DDRAM_PREFETCH_EN
                                if (pf_addr_q[j] == g_addr) pf_valid_d[j] = 1'b0;
`endif
                            end
                        end
                    end else if (line_hit) begin
                        ready_d[gnt_idx] = 1'b1;
`ifdef DDRAM_PREFETCH_EN
                    end else if (pf_hit) begin
                        // Promote the prefetch line and refill prefetch with the following word.
                        dout_d[gnt_idx]       = pf_data_q[gnt_idx];
                        line_addr_d[gnt_idx]  = g_addr;
                        line_valid_d[gnt_idx] = 1'b1;
                        pf_valid_d[gnt_idx]   = 1'b0;
                        ready_d[gnt_idx]      = 1'b1;
                        rd_d     = 1'b1;
                        be_d     = 8'hFF;
                        addr_d   = g_addr + 25'd1;
                        burst_d  = 8'd1;
                        refill_d = 1'b1;
                        state_d  = CMD;
`endif
                    end else begin
                        rd_d    = 1'b1;
                        be_d    = 8'hFF;
                        burst_d = CACHED[gnt_idx] ? MISS_BURST : 8'd1;
`ifdef DDRAM_PREFETCH_EN
                        refill_d = 1'b0;
`endif
                        state_d = CMD;
                    end
                end
            end
            CMD: begin
                if (!DDRAM_BUSY) begin
                    rd_d = 1'b0;
                    we_d = 1'b0;
                    if (we_q) begin
                        ready_d[gnt_q] = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RD1;
                    end
                end
            end
            RD1: begin
                if (DDRAM_DOUT_READY) begin
`ifdef DDRAM_PREFETCH_EN
                    if (refill_q) begin
                        pf_data_d[gnt_q]  = DDRAM_DOUT;
                        pf_addr_d[gnt_q]  = addr_q;
                        pf_valid_d[gnt_q] = 1'b1;
                        state_d = IDLE;
                    end else
`endif
                    begin
                        dout_d[gnt_q]  = DDRAM_DOUT;
                        ready_d[gnt_q] = 1'b1;
                        if (CACHED[gnt_q]) begin
                            line_valid_d[gnt_q] = 1'b1;
                            line_addr_d[gnt_q]  = addr_q;
                        end
                        state_d = (burst_q == 8'd2) ? RD2 : IDLE;
                    end
                end
            end
            RD2: begin
`ifdef DDRAM_PREFETCH_EN
                if (DDRAM_DOUT_READY) begin
                    pf_data_d[gnt_q]  = DDRAM_DOUT;
                    pf_addr_d[gnt_q]  = addr_q + 25'd1;
                    pf_valid_d[gnt_q] = 1'b1;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge DDRAM_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            gnt_q        <= '0;
            pend_q       <= '0;
            req_addr_q   <= '{default: '0};
            req_din_q    <= '{default: '0};
            req_be_q     <= '{default: '0};
            req_rnw_q    <= '0;
            line_valid_q <= '0;
            line_addr_q  <= '{default: '0};
            dout_q       <= '{default: '0};
            ready_q      <= '0;
            rd_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            be_q         <= '0;
            burst_q      <= 8'd1;
`ifdef DDRAM_PREFETCH_EN
            pf_valid_q   <= '0;
            pf_addr_q    <= '{default: '0};
            pf_data_q    <= '{default: '0};
            refill_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            pend_q       <= pend_d;
            req_addr_q   <= req_addr_d;
            req_din_q    <= req_din_d;
            req_be_q     <= req_be_d;
            req_rnw_q    <= req_rnw_d;
            line_valid_q <= line_valid_d;
            line_addr_q  <= line_addr_d;
            dout_q       <= dout_d;
            ready_q      <= ready_d;
            rd_q         <= rd_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            be_q         <= be_d;
            burst_q      <= burst_d;
`ifdef DDRAM_PREFETCH_EN
            pf_valid_q   <= pf_valid_d;
            pf_addr_q    <= pf_addr_d;
            pf_data_q    <= pf_data_d;
            refill_q     <= refill_d;
`endif
        end
    end

    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_ADDR     = {BASE_ADDR, addr_q};
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;
    assign DDRAM_BURSTCNT = burst_q;
    assign ch_ready       = ready_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dout
        assign ch_dout[gi*64 +: 64] = dout_q[gi];
    end
endmodule

// File: tb/tb_ddram_mux.sv
// Directed bench for ddram_mux: a small DDR responder model answers reads and merges writes; expected values are hand-computed.
module tb_ddram_mux;
    localparam int NUM_CH = 4;
`ifdef DDRAM_PREFETCH_EN
    localparam int EXP_BURST = 2;
`else
    localparam int EXP_BURST = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n_tb = 1'b1;
    logic                 busy = 1'b0;
    logic [7:0]           burstcnt;
    logic [28:0]          ddr_addr;
    logic [63:0]          ddr_dout = '0;
    logic                 ddr_dout_ready = 1'b0;
    logic                 ddr_rd, ddr_we;
    logic [63:0]          ddr_din;
    logic [7:0]           ddr_be;
    logic [NUM_CH*25-1:0] ch_addr = '0;
    logic [NUM_CH*64-1:0] ch_din = '0;
    logic [NUM_CH*8-1:0]  ch_be = '0;
    logic [NUM_CH-1:0]    ch_req = '0;
    logic [NUM_CH-1:0]    ch_rnw = '0;
    logic [NUM_CH*64-1:0] ch_dout;
    logic [NUM_CH-1:0]    ch_ready;

    always #5 clk = ~clk;

    ddram_mux #(.NUM_CH(NUM_CH)) dut (
        .DDRAM_CLK(clk), .DDRAM_RESET_N(rst_n_tb), .DDRAM_BUSY(busy),
        .DDRAM_BURSTCNT(burstcnt), .DDRAM_ADDR(ddr_addr), .DDRAM_DOUT(ddr_dout),
        .DDRAM_DOUT_READY(ddr_dout_ready), .DDRAM_RD(ddr_rd), .DDRAM_DIN(ddr_din),
        .DDRAM_BE(ddr_be), .DDRAM_WE(ddr_we), .ch_addr(ch_addr), .ch_din(ch_din),
        .ch_be(ch_be), .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_dout(ch_dout), .ch_ready(ch_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // DDR responder: beats arrive two cycles after acceptance, one per cycle.
    typedef struct { logic [63:0] data; int due; } beat_t;
    beat_t       beats[$];
    logic [63:0] mem [logic [24:0]];
    int          cyc = 0, rd_cnt = 0, we_cnt = 0;
    logic [28:0] last_rd_addr = '0, last_we_addr = '0;
    logic [7:0]  last_burst = '0, last_be = '0;
    logic [63:0] last_din = '0;
    logic [28:0] rd_log[$];
    int          rdy_log[$];
    int          rdy_cnt[NUM_CH];

    function automatic logic [63:0] pat(input logic [24:0] a);
        return 64'hC0DE_0000_0000_0000 | {39'd0, a};
    endfunction

    function automatic logic [63:0] rdmem(input logic [24:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    initial begin : responder
        logic [63:0] w;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (beats.size() > 0 && beats[0].due <= cyc) begin
                ddr_dout       = beats[0].data;
                ddr_dout_ready = 1'b1;
                void'(beats.pop_front());
            end else begin
                ddr_dout_ready = 1'b0;
            end
            if (ddr_rd && !busy) begin
                rd_cnt++;
                last_rd_addr = ddr_addr;
                last_burst   = burstcnt;
                rd_log.push_back(ddr_addr);
                for (int b = 0; b < int'(burstcnt); b++)
                    beats.push_back('{data: rdmem(ddr_addr[24:0] + 25'(b)), due: cyc + 2 + b});
            end
            if (ddr_we && !busy) begin
                we_cnt++;
                last_we_addr = ddr_addr;
                last_be      = ddr_be;
                last_din     = ddr_din;
                w = rdmem(ddr_addr[24:0]);
                for (int k = 0; k < 8; k++)
                    if (ddr_be[k]) w[k*8 +: 8] = ddr_din[k*8 +: 8];
                mem[ddr_addr[24:0]] = w;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_ready[i]) begin
                    rdy_cnt[i]++;
                    rdy_log.push_back(i);
                end
            end
        end
    end

    // Issues one request and returns the number of negedges until ch_ready.
    task automatic do_req(input int ch, input logic rnw, input logic [24:0] a,
                          input logic [63:0] d, input logic [7:0] be, output int lat);
        @(negedge clk);
        ch_addr[ch*25 +: 25] = a;
        ch_din[ch*64 +: 64]  = d;
        ch_be[ch*8 +: 8]     = be;
        ch_rnw[ch]           = rnw;
        ch_req[ch]           = 1'b1;
        lat = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            ch_req[ch] = 1'b0;
            lat++;
            if (ch_ready[ch]) break;
        end
        chk($sformatf("done_ch%0d_%h", ch, a), 64'(ch_ready[ch]), 64'd1);
        #3;
        $display("req ch%0d rnw=%0b addr=%h lat=%0d dout=%h", ch, rnw, a, lat, ch_dout[ch*64 +: 64]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, r0, w0, act, bad, done;
        logic [28:0] exp_rd[4];
        int exp_order[4];
        exp_rd    = '{29'h0600_0320, 29'h0600_0330, 29'h0600_0300, 29'h0600_0310};
        exp_order = '{2, 3, 0, 1};

        #1 rst_n_tb = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_rd", 64'(ddr_rd), 64'd0);
        chk("rst_ready", 64'(ch_ready), 64'd0);
        rst_n_tb = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (ddr_rd || ddr_we) act++;
        end
        chk("idle_cmds", 64'(act), 64'd0);
        chk("rst_burst", 64'(burstcnt), 64'd1);
        chk("rst_be", 64'(ddr_be), 64'd0);
        chk("rst_dout", ch_dout[63:0] | ch_dout[127:64] | ch_dout[191:128] | ch_dout[255:192], 64'd0);

        // Miss then hit on channel 0.
        r0 = rd_cnt;
        do_req(0, 1'b1, 25'h20, 64'd0, 8'h00, lat);
        chk("miss_rdcnt", 64'(rd_cnt - r0), 64'd1);
        chk("miss_addr", 64'(last_rd_addr), 64'h0600_0020);
        chk("miss_burst", 64'(last_burst), 64'(EXP_BURST));
        chk("miss_dout", ch_dout[63:0], 64'hC0DE_0000_0000_0020);
        idle(8);
        do_req(0, 1'b1, 25'h20, 64'd0, 8'h00, lat);
        chk("hit_lat", 64'(lat), 64'd2);
        chk("hit_rdcnt", 64'(rd_cnt - r0), 64'd1);
        chk("hit_dout", ch_dout[63:0], 64'hC0DE_0000_0000_0020);
        idle(8);

        // Write from channel 1 invalidates channel 0's cached line.
        do_req(0, 1'b1, 25'h40, 64'd0, 8'h00, lat);
        idle(8);
        do_req(0, 1'b1, 25'h40, 64'd0, 8'h00, lat);
        chk("hit40_lat", 64'(lat), 64'd2);
        r0 = rd_cnt;
        w0 = we_cnt;
        do_req(1, 1'b0, 25'h40, 64'h0000_0000_1122_3344, 8'h0F, lat);
        chk("wr_cnt", 64'(we_cnt - w0), 64'd1);
        chk("wr_be", 64'(last_be), 64'h0F);
        chk("wr_din", last_din, 64'h0000_0000_1122_3344);
        chk("wr_addr", 64'(last_we_addr), 64'h0600_0040);
        idle(4);
        do_req(0, 1'b1, 25'h40, 64'd0, 8'h00, lat);
        chk("inval_rdcnt", 64'(rd_cnt - r0), 64'd1);
        chk("inval_dout", ch_dout[63:0], 64'hC0DE_0000_1122_3344);
        idle(8);

        // Channel 1 read leaves rr_ptr at 2, then all channels request together.
        do_req(1, 1'b1, 25'h10, 64'd0, 8'h00, lat);
        idle(8);
        rd_log.delete();
        rdy_log.delete();
        for (int i = 0; i < NUM_CH; i++) rdy_cnt[i] = 0;
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr[i*25 +: 25] = 25'h300 + 25'(i * 16);
            ch_rnw[i] = 1'b1;
        end
        ch_req = '1;
        @(negedge clk);
        ch_req = '0;
        done = 0;
        for (int n = 0; n < 300 && done == 0; n++) begin
            @(negedge clk);
            #3;
            if (rdy_cnt[0] > 0 && rdy_cnt[1] > 0 && rdy_cnt[2] > 0 && rdy_cnt[3] > 0) done = 1;
        end
        idle(20);
        for (int i = 0; i < NUM_CH; i++)
            chk($sformatf("rr_ready_cnt%0d", i), 64'(rdy_cnt[i]), 64'd1);
        chk("rr_ncmd", 64'(rd_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_addr%0d", k), 64'(k < rd_log.size() ? rd_log[k] : 29'h1FFF_FFFF), 64'(exp_rd[k]));
            chk($sformatf("rr_order%0d", k), 64'(k < rdy_log.size() ? rdy_log[k] : 99), 64'(exp_order[k]));
        end
        chk("rr_dout3", ch_dout[255:192], 64'hC0DE_0000_0000_0330);

        // Write held off by BUSY for 10 cycles.
        @(negedge clk);
        busy = 1'b1;
        ch_addr[3*25 +: 25] = 25'h50;
        ch_din[3*64 +: 64]  = 64'hCAFE_BABE_0123_4567;
        ch_be[3*8 +: 8]     = 8'hFF;
        ch_rnw[3]           = 1'b0;
        ch_req[3]           = 1'b1;
        @(negedge clk);
        ch_req[3] = 1'b0;
        for (int n = 0; n < 20 && !ddr_we; n++) @(negedge clk);
        chk("busy_we_seen", 64'(ddr_we), 64'd1);
        w0  = we_cnt;
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            if (!(ddr_we && ddr_addr == 29'h0600_0050 && ddr_din == 64'hCAFE_BABE_0123_4567 && !ch_ready[3])) bad++;
            @(negedge clk);
        end
        chk("busy_stable", 64'(bad), 64'd0);
        chk("busy_noready", 64'(ch_ready[3]), 64'd0);
        busy = 1'b0;
        @(negedge clk);
        chk("busy_ready", 64'(ch_ready[3]), 64'd1);
        chk("busy_we_drop", 64'(ddr_we), 64'd0);
        #3;
        chk("busy_wcnt", 64'(we_cnt - w0), 64'd1);
        idle(8);

`ifdef DDRAM_PREFETCH_EN
        // Prefetch: 0x200 miss fills 0x201, which is then served locally while 0x202 is refilled.
        r0 = rd_cnt;
        do_req(0, 1'b1, 25'h200, 64'd0, 8'h00, lat);
        chk("pf_burst", 64'(last_burst), 64'd2);
        chk("pf_addr", 64'(last_rd_addr), 64'h0600_0200);
        idle(8);
        do_req(0, 1'b1, 25'h201, 64'd0, 8'h00, lat);
        chk("pf_lat", 64'(lat), 64'd2);
        chk("pf_dout", ch_dout[63:0], 64'hC0DE_0000_0000_0201);
        idle(10);
        chk("pf_rdcnt", 64'(rd_cnt - r0), 64'd2);
        chk("pf_refill_addr", 64'(last_rd_addr), 64'h0600_0202);
        chk("pf_refill_burst", 64'(last_burst), 64'd1);
        do_req(0, 1'b1, 25'h202, 64'd0, 8'h00, lat);
        chk("pf2_lat", 64'(lat), 64'd2);
        chk("pf2_dout", ch_dout[63:0], 64'hC0DE_0000_0000_0202);
        idle(10);
`endif

        // Reset while a read is in flight: late beats must be ignored and caches cleared.
        rdy_cnt[2] = 0;
        r0 = rd_cnt;
        @(negedge clk);
        ch_addr[2*25 +: 25] = 25'h400;
        ch_rnw[2] = 1'b1;
        ch_req[2] = 1'b1;
        @(negedge clk);
        ch_req[2] = 1'b0;
        for (int n = 0; n < 20 && rd_cnt == r0; n++) begin
            @(negedge clk);
            #2;
        end
        chk("mid_rd_issued", 64'(rd_cnt - r0), 64'd1);
        rst_n_tb = 1'b0;
        repeat (4) @(negedge clk);
        rst_n_tb = 1'b1;
        idle(10);
        chk("mid_noready", 64'(rdy_cnt[2]), 64'd0);
        chk("mid_dout", ch_dout[191:128], 64'd0);
        r0 = rd_cnt;
        do_req(0, 1'b1, 25'h20, 64'd0, 8'h00, lat);
        chk("mid_cache_cleared", 64'(rd_cnt - r0), 64'd1);
        chk("mid_dout0", ch_dout[63:0], 64'hC0DE_0000_0000_0020);
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
